// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants: XLEN, bubble encoding, next-PC select codes, IF/ID payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register: flush > stall > imem-not-ready bubble > load, plus register-field slices.
module fetch_decode_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        ImemReadyF,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [4:0]  RS1D,
  output logic [4:0]  RS2D,
  output logic [4:0]  RDD,
  output logic        ValidD
);
  import riscv_pkg::*;

  ifid_t bubble;
  ifid_t ifid_d, ifid_q;

  assign bubble = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

  always_comb begin
    ifid_d = ifid_q;
    if (FlushD) begin
      ifid_d = bubble;
    end else if (StallD) begin
      ifid_d = ifid_q;
    end else if (!ImemReadyF) begin
      ifid_d = bubble;
    end else begin
      ifid_d = '{instr: InstrF, pc: PCF, pc_plus4: PCF + 32'd4, valid: 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q <= bubble;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc_plus4;
  assign ValidD   = ifid_q.valid;
  assign RS1D     = ifid_q.instr[19:15];
  assign RS2D     = ifid_q.instr[24:20];
  assign RDD      = ifid_q.instr[11:7];

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC select, misalignment pulse and IF/ID register.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] InstrF,
  input  logic        ImemReadyF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [4:0]  RS1D,
  output logic [4:0]  RS2D,
  output logic [4:0]  RDD,
  output logic        ValidD,
  output logic        MisalignF,
  output logic [31:0] InstrCnt,
  output logic [31:0] BubbleCnt,
  output logic [31:0] StallCnt
);
  import riscv_pkg::*;

  logic [31:0] pc_d, pc_q;
  logic        misalign_d, misalign_q;
  logic        redirect;
  logic [31:0] target;

  assign redirect = (PCSrcE == PCSRC_BR) || (PCSrcE == PCSRC_JALR);
  // jalr clears bit 0 before alignment, so only bit 1 can flag it misaligned
  assign target   = (PCSrcE == PCSRC_BR) ? PCTargetE : (ALUResultE & 32'hFFFF_FFFE);

  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (redirect) begin
      pc_d       = word_align(target);
      misalign_d = (target[1:0] != 2'b00);
    end else if (StallF || !ImemReadyF) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign PCF       = pc_q;
  assign MisalignF = misalign_q;

  fetch_decode_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .ImemReadyF (ImemReadyF),
    .InstrF     (InstrF),
    .PCF        (pc_q),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .RS1D       (RS1D),
    .RS2D       (RS2D),
    .RDD        (RDD),
    .ValidD     (ValidD)
  );

`ifdef FETCH_PERF_CNT_EN
  logic        load_real, load_bubble, stall_hit;
  logic [31:0] instr_cnt_d, instr_cnt_q;
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;

  assign load_real   = !FlushD && !StallD && ImemReadyF;
  assign load_bubble = FlushD || (!StallD && !ImemReadyF);
  assign stall_hit   = StallD && !FlushD;

  // Counters saturate at all-ones rather than wrapping
  always_comb begin
    instr_cnt_d  = instr_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (load_real && (instr_cnt_q != '1)) instr_cnt_d = instr_cnt_q + 32'd1;
    if (load_bubble && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (stall_hit && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      instr_cnt_q  <= instr_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign InstrCnt  = instr_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
  assign StallCnt  = stall_cnt_q;
`else
  assign InstrCnt  = 32'b0;
  assign BubbleCnt = 32'b0;
  assign StallCnt  = 32'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF state queued per cycle, popped and checked after the edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, ImemReadyF;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE, ALUResultE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, InstrCnt, BubbleCnt, StallCnt;
  logic [4:0]  RS1D, RS2D, RDD;
  logic        ValidD, MisalignF;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcp4;
    logic        valid;
    logic        mis;
    logic [31:0] ic;
    logic [31:0] bc;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;

  fetch_stage u_dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .ALUResultE (ALUResultE),
    .InstrF     (InstrF),
    .ImemReadyF (ImemReadyF),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .RS1D       (RS1D),
    .RS2D       (RS2D),
    .RDD        (RDD),
    .ValidD     (ValidD),
    .MisalignF  (MisalignF),
    .InstrCnt   (InstrCnt),
    .BubbleCnt  (BubbleCnt),
    .StallCnt   (StallCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h00A0_8233;
  endfunction

  assign InstrF = imem(PCF);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".PCF"}, PCF, e.pc);
    check({tag, ".InstrD"}, InstrD, e.instr);
    check({tag, ".PCD"}, PCD, e.pcd);
    check({tag, ".PCPlus4D"}, PCPlus4D, e.pcp4);
    check({tag, ".ValidD"}, {31'b0, ValidD}, {31'b0, e.valid});
    check({tag, ".MisalignF"}, {31'b0, MisalignF}, {31'b0, e.mis});
    check({tag, ".RS1D"}, {27'b0, RS1D}, {27'b0, e.instr[19:15]});
    check({tag, ".RS2D"}, {27'b0, RS2D}, {27'b0, e.instr[24:20]});
    check({tag, ".RDD"}, {27'b0, RDD}, {27'b0, e.instr[11:7]});
    check({tag, ".InstrCnt"}, InstrCnt, e.ic);
    check({tag, ".BubbleCnt"}, BubbleCnt, e.bc);
    check({tag, ".StallCnt"}, StallCnt, e.sc);
  endtask

  function automatic exp_t reset_state();
    exp_t r;
    r = '0;
    r.pc    = 32'h0;
    r.instr = 32'h0000_0013;
    return r;
  endfunction

  // One clock: build expectation from the current inputs, queue it, clock, pop and compare.
  task automatic step(input string tag);
    exp_t e;
    logic        redir;
    logic [31:0] tgt;
    e     = m;
    redir = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    tgt   = (PCSrcE == 2'b01) ? PCTargetE : {ALUResultE[31:1], 1'b0};
    if (redir) e.pc = {tgt[31:2], 2'b00};
    else if (!StallF && ImemReadyF) e.pc = m.pc + 32'd4;
    e.mis = redir && (tgt[1:0] != 2'b00);
    if (FlushD || (!StallD && !ImemReadyF)) begin
      e.instr = 32'h0000_0013; e.pcd = '0; e.pcp4 = '0; e.valid = 1'b0;
    end else if (!StallD) begin
      e.instr = imem(m.pc); e.pcd = m.pc; e.pcp4 = m.pc + 32'd4; e.valid = 1'b1;
    end
`ifdef FETCH_PERF_CNT_EN
    if (FlushD || (!StallD && !ImemReadyF)) e.bc = m.bc + 1;
    else if (!StallD) e.ic = m.ic + 1;
    if (StallD && !FlushD) e.sc = m.sc + 1;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    m = e;
    check_all(tag, e);
  endtask

  task automatic idle_inputs();
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 2'b00;
    PCTargetE = '0; ALUResultE = '0; ImemReadyF = 1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    check_all("reset", reset_state());
    @(posedge clk);
    #1;
    rst = 1'b0;
    m = reset_state();
    exp_q.delete();

    step("seq0");
    step("seq1");
    ImemReadyF = 0;
    step("wait0");
    step("wait1");
    ImemReadyF = 1;
    step("resume8");
    step("seqC");

    StallF = 1; StallD = 1;
    step("stall0");
    step("stall1");
    StallF = 0; StallD = 0;
    step("unstall");

    PCSrcE = 2'b01; PCTargetE = 32'h0000_0100; FlushD = 1;
    step("br_flush");
    idle_inputs();
    step("br_land");

    PCSrcE = 2'b10; ALUResultE = 32'h0000_0203;
    step("jalr_mis");
    idle_inputs();
    step("mis_clear");
    PCSrcE = 2'b11;
    step("pcsrc11");

    PCSrcE = 2'b01; PCTargetE = 32'h0000_0302; StallF = 1; ImemReadyF = 0; FlushD = 1;
    step("redir_wins");
    idle_inputs();
    step("after_redir");

    PCSrcE = 2'b01; PCTargetE = 32'hFFFF_FFFC; FlushD = 1;
    step("to_top");
    idle_inputs();
    step("wrap");

    StallD = 1; FlushD = 1;
    step("flush_over_stall");
    idle_inputs();
    StallD = 1;
    step("stallD_only");
    idle_inputs();

    PCSrcE = 2'b01; PCTargetE = 32'h0000_0040; FlushD = 1;
    step("to_40");
    idle_inputs();
    ImemReadyF = 0;
    step("wait40");
    #3;
    rst = 1'b1;
    #1;
    check_all("rst_mid_wait", reset_state());
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    m = reset_state();
    exp_q.delete();
    step("refetch");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
